// File: rtl/audio_adc_pkg.sv
// -----------------------------------------------------------------------------
// audio_adc_pkg
// Shared constants for the audio ADC capture controller: Avalon-MM register
// addresses, CTRL/STATUS bit positions and the capture FSM state encoding.
// -----------------------------------------------------------------------------
package audio_adc_pkg;

    // Register map (word addresses on the 2-bit slave address bus)
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LEFT  = 2'd1;
    localparam logic [1:0] ADDR_RIGHT = 2'd2;
    localparam logic [1:0] ADDR_RSVD  = 2'd3;

    // CTRL/STATUS bit positions
    localparam int CTRL_ENABLE_BIT = 32'sd0;
    localparam int CTRL_IRQ_EN_BIT = 32'sd1;
    localparam int CTRL_EMPTY_BIT  = 32'sd2;
    localparam int CTRL_OVF_BIT    = 32'sd3;
    localparam int CTRL_LEVEL_LSB  = 32'sd8;

    // Capture FSM states; explicit encodings keep the state register stable
    // across tools and match older netlists that used raw 3-bit constants.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SKIP_L  = 3'd1,
        ST_SHIFT_L = 3'd2,
        ST_WAIT_R  = 3'd3,
        ST_SKIP_R  = 3'd4,
        ST_SHIFT_R = 3'd5,
        ST_WAIT_L  = 3'd6
    } capture_state_e;

endpackage

// File: rtl/audio_adc_capture_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding {left,right} sample pairs.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, wdata      : write request and data (ignored when full unless popping)
//   pop              : read request (ignored when empty)
//   rdata            : head-of-FIFO entry (show-ahead)
//   full, empty      : occupancy flags
//   level            : number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push_s;
    logic              do_pop_s;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer, occupancy and storage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/audio_adc_capture_ctrl.sv
// -----------------------------------------------------------------------------
// audio_adc_capture_ctrl
// Avalon-MM slave that captures I2S stereo samples from the codec ADC port
// (codec is clock master) and buffers left/right pairs for CPU readout.
// Ports:
//   clk, reset_n                 : system clock (>= 4x BCLK), async active-low reset
//   address/chipselect/read/write/writedata/readdata : Avalon-MM slave, 1-cycle read latency
//   adclrc, bclk, adcdat         : asynchronous codec serial inputs
//   irq                          : level interrupt, enable & irq_en & FIFO not empty
// -----------------------------------------------------------------------------
module audio_adc_capture_ctrl
    import audio_adc_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        adclrc,
    input  logic        bclk,
    input  logic        adcdat,
    output logic        irq
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronisers and edge history
    logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
    logic lrc_meta_q, lrc_sync_q, lrc_last_q, lrc_last_d;
    logic dat_meta_q, dat_sync_q;
    logic bclk_rise_s, lrc_fall_s, lrc_rise_s, lrc_edge_s;

    // Capture path
    capture_state_e      state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d, shift_next_s;
    logic [DATA_W-1:0]   left_q, left_d;
    logic                push_s;

    // Control/status
    logic enable_q, enable_d;
    logic irq_en_q, irq_en_d;
    logic overflow_q, overflow_d;
    logic ovf_set_s, ovf_clr_s;
    logic [31:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;
    logic        pop_s;

    // FIFO interface
    logic [2*DATA_W-1:0] fifo_rdata_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [LVL_W-1:0]    fifo_level_s;
    logic [DATA_W-1:0]   head_left_s, head_right_s;
    logic [31:0]         status_s;
    logic                wdata_unused_s;

    assign wdata_unused_s = ^{writedata[31:4], writedata[2]};

    assign bclk_rise_s  = bclk_sync_q & ~bclk_prev_q;
    // LRC is only looked at on BCLK rising edges, where the codec guarantees it is stable.
    assign lrc_fall_s   = bclk_rise_s & lrc_last_q & ~lrc_sync_q;
    assign lrc_rise_s   = bclk_rise_s & ~lrc_last_q & lrc_sync_q;
    assign lrc_edge_s   = lrc_fall_s | lrc_rise_s;
    assign shift_next_s = {shift_q[DATA_W-2:0], dat_sync_q};

    // LRC history advances on BCLK rising edges only
    always_comb begin
        if (bclk_rise_s) begin
            lrc_last_d = lrc_sync_q;
        end else begin
            lrc_last_d = lrc_last_q;
        end
    end

    // Capture FSM: frame alignment, delay-bit skip and MSB-first deserialisation
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        push_s    = 1'b0;
        if (!enable_q) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else if (bclk_rise_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (lrc_fall_s) begin
                        state_d = ST_SKIP_L;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SKIP_L: begin
                    state_d   = ST_SHIFT_L;
                    bit_cnt_d = '0;
                end
                ST_SHIFT_L: begin
                    if (lrc_edge_s) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d = shift_next_s;
                        if (bit_cnt_q == LAST_BIT) begin
                            left_d    = shift_next_s;
                            bit_cnt_d = '0;
                            state_d   = ST_WAIT_R;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (lrc_rise_s) begin
                        state_d = ST_SKIP_R;
                    end else if (lrc_fall_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
                ST_SKIP_R: begin
                    state_d   = ST_SHIFT_R;
                    bit_cnt_d = '0;
                end
                ST_SHIFT_R: begin
                    if (lrc_edge_s) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d = shift_next_s;
                        if (bit_cnt_q == LAST_BIT) begin
                            push_s    = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = ST_WAIT_L;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_L: begin
                    if (lrc_fall_s) begin
                        state_d = ST_SKIP_L;
                    end else if (lrc_rise_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_L;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // CTRL writes and sticky overflow; a new overflow wins over a same-cycle clear
    always_comb begin
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        ovf_clr_s = 1'b0;
        if (chipselect && write && (address == ADDR_CTRL)) begin
            enable_d  = writedata[CTRL_ENABLE_BIT];
            irq_en_d  = writedata[CTRL_IRQ_EN_BIT];
            ovf_clr_s = writedata[CTRL_OVF_BIT];
        end else begin
            ovf_clr_s = 1'b0;
        end
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign ovf_set_s    = push_s & fifo_full_s & ~pop_s;
    assign head_left_s  = fifo_rdata_s[2*DATA_W-1:DATA_W];
    assign head_right_s = fifo_rdata_s[DATA_W-1:0];

    // Status word assembly
    always_comb begin
        status_s                                 = 32'h0000_0000;
        status_s[CTRL_ENABLE_BIT]                = enable_q;
        status_s[CTRL_IRQ_EN_BIT]                = irq_en_q;
        status_s[CTRL_EMPTY_BIT]                 = fifo_empty_s;
        status_s[CTRL_OVF_BIT]                   = overflow_q;
        status_s[CTRL_LEVEL_LSB +: LVL_W]        = fifo_level_s;
    end

    // Read mux; RIGHT read is the pop point so a pair is consumed LEFT-then-RIGHT
    always_comb begin
        readdata_d = readdata_q;
        pop_s      = 1'b0;
        if (chipselect && read) begin
            case (address)
                ADDR_CTRL: readdata_d = status_s;
                ADDR_LEFT: begin
                    if (fifo_empty_s) begin
                        readdata_d = 32'h0000_0000;
                    end else begin
                        readdata_d = {{(32-DATA_W){head_left_s[DATA_W-1]}}, head_left_s};
                    end
                end
                ADDR_RIGHT: begin
                    if (fifo_empty_s) begin
                        readdata_d = 32'h0000_0000;
                    end else begin
                        readdata_d = {{(32-DATA_W){head_right_s[DATA_W-1]}}, head_right_s};
                        pop_s      = 1'b1;
                    end
                end
                default: readdata_d = 32'h0000_0000;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    assign irq_d    = enable_q & irq_en_q & ~fifo_empty_s;
    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Two-flop synchronisers for the asynchronous codec inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_meta_q <= 1'b0;
            bclk_sync_q <= 1'b0;
            bclk_prev_q <= 1'b0;
            lrc_meta_q  <= 1'b0;
            lrc_sync_q  <= 1'b0;
            lrc_last_q  <= 1'b0;
            dat_meta_q  <= 1'b0;
            dat_sync_q  <= 1'b0;
        end else begin
            bclk_meta_q <= bclk;
            bclk_sync_q <= bclk_meta_q;
            bclk_prev_q <= bclk_sync_q;
            lrc_meta_q  <= adclrc;
            lrc_sync_q  <= lrc_meta_q;
            lrc_last_q  <= lrc_last_d;
            dat_meta_q  <= adcdat;
            dat_sync_q  <= dat_meta_q;
        end
    end

    // Capture FSM, control and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            left_q     <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            readdata_q <= 32'h0000_0000;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    sync_fifo #(
        .DATA_W (2*DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .wdata   ({left_q, shift_next_s}),
        .pop     (pop_s),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

endmodule
